// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the device over the shared open-drain clock/data
// pins: inhibit, request-to-send, ten device-clocked bits, then the device ACK.
// The device clock is glitch-filtered and only its filtered falling edges
// advance the frame. A watchdog aborts the frame if the device stops clocking.
//
// Handshake: tx_data is accepted on a cycle where tx_valid && tx_ready; the
// byte is latched on that edge and tx_ready drops the following cycle. A
// tx_valid without tx_ready is ignored, never queued. Each accepted byte ends
// with exactly one one-cycle pulse, tx_done (ACKed) or tx_err (timeout / no ACK).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,   // must be >= 2
  parameter int TIMEOUT_CYCLES = 750000, // must be >= 1
  parameter int FILTER_LEN     = 16      // must be >= 2
) (
  input  logic       c50,
  input  logic       reset_all,
  input  logic       pc,
  input  logic       pd,
  output logic       pc_drive_low,
  output logic       pd_drive_low,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [2:0] dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;

  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] INH_LAST   = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_START  = IW'(INHIBIT_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_DATA      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  // Glitch filter and synchronisers
  logic [FILTER_LEN-1:0] filt_q;
  logic [FILTER_LEN-1:0] filt_d;
  logic                  pcf_q;
  logic                  pcf_d;
  logic                  fall_q;
  logic                  pd_s1_q;
  logic                  pd_s2_q;

  // Transmit FSM registers
  state_t          state_q;
  logic [7:0]      data_q;
  logic            par_q;
  logic [3:0]      bit_q;
  logic [TW-1:0]   timer_q;
  logic [IW-1:0]   inh_q;
  logic            pc_low_q;
  logic            pd_low_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic            active;
  logic            tmo_hit;

  // Filtered clock level: follows pc only once FILTER_LEN samples agree
  always_comb begin
    filt_d = {filt_q[FILTER_LEN-2:0], pc};
    pcf_d  = pcf_q;
    if (&filt_q) begin
      pcf_d = 1'b1;
    end else if (~|filt_q) begin
      pcf_d = 1'b0;
    end
  end

  // Filter shift register, registered falling-edge strobe, pd synchroniser
  always_ff @(posedge c50 or negedge reset_all) begin
    if (!reset_all) begin
      filt_q  <= '1;
      pcf_q   <= 1'b1;
      fall_q  <= 1'b0;
      pd_s1_q <= 1'b1;
      pd_s2_q <= 1'b1;
    end else begin
      filt_q  <= filt_d;
      pcf_q   <= pcf_d;
      fall_q  <= pcf_q & ~pcf_d;
      pd_s1_q <= pd;
      pd_s2_q <= pd_s1_q;
    end
  end

  // Watchdog is armed in every state that waits on the device
  always_comb begin
    active  = (state_q == S_REQ) || (state_q == S_DATA) ||
              (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    // Firing when the incremented value would reach the limit places tx_err
    // exactly TIMEOUT_CYCLES cycles after the last clear.
    tmo_hit = active && !fall_q && (timer_q >= TIMER_LAST);
  end

  // Transmit sequencer with registered line drives and status outputs
  always_ff @(posedge c50 or negedge reset_all) begin
    if (!reset_all) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      bit_q    <= '0;
      timer_q  <= '0;
      inh_q    <= '0;
      pc_low_q <= 1'b0;
      pd_low_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (active) begin
        if (fall_q) begin
          timer_q <= '0;
        end else if (timer_q != TIMER_MAX) begin
          timer_q <= timer_q + TW'(1);
        end
      end

      if (tmo_hit && !(state_q == S_WAIT_IDLE && pcf_q && pd_s2_q)) begin
        pc_low_q <= 1'b0;
        pd_low_q <= 1'b0;
        err_q    <= 1'b1;
        ready_q  <= 1'b1;
        busy_q   <= 1'b0;
        state_q  <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (tx_valid && ready_q) begin
              data_q   <= tx_data;
              par_q    <= ~^tx_data;
              inh_q    <= '0;
              bit_q    <= '0;
              timer_q  <= '0;
              pc_low_q <= 1'b1;
              ready_q  <= 1'b0;
              busy_q   <= 1'b1;
              state_q  <= S_INHIBIT;
            end
          end

          S_INHIBIT: begin
            inh_q <= inh_q + IW'(1);
            // Start bit goes out during the final inhibit cycle
            if (inh_q == INH_START) begin
              pd_low_q <= 1'b1;
            end
            if (inh_q == INH_LAST) begin
              pc_low_q <= 1'b0;
              timer_q  <= '0;
              state_q  <= S_REQ;
            end
          end

          S_REQ: begin
            if (fall_q) begin
              pd_low_q <= ~data_q[0];
              bit_q    <= 4'd1;
              state_q  <= S_DATA;
            end
          end

          S_DATA: begin
            // Data changes only the cycle after a fall, while clock is low
            if (fall_q) begin
              bit_q <= bit_q + 4'd1;
              if (bit_q <= 4'd7) begin
                pd_low_q <= ~data_q[bit_q[2:0]];
              end else if (bit_q == 4'd8) begin
                pd_low_q <= ~par_q;
              end else begin
                pd_low_q <= 1'b0;
                state_q  <= S_ACK;
              end
            end
          end

          S_ACK: begin
            if (fall_q) begin
              if (!pd_s2_q) begin
                state_q <= S_WAIT_IDLE;
              end else begin
                err_q   <= 1'b1;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end
          end

          S_WAIT_IDLE: begin
            if (pcf_q && pd_s2_q) begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end

          default: begin
            pc_low_q <= 1'b0;
            pd_low_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign pc_drive_low = pc_low_q;
  assign pd_drive_low = pd_low_q;
  assign tx_ready     = ready_q;
  assign busy         = busy_q;
  assign tx_done      = done_q;
  assign tx_err       = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device drives the clock, samples
// host data on its rising edges and optionally ACKs. The expected frame for
// each byte is built from the byte value alone (start, LSB-first data, odd
// parity, stop) and checked bit by bit through an expected queue.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 60;
  localparam int TMO  = 3000;
  localparam int FLEN = 16;
  localparam int HALF = 40;
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic       c50 = 1'b0;
  logic       reset_all = 1'b0;
  logic       pc;
  logic       pd;
  logic       pc_drive_low;
  logic       pd_drive_low;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic [2:0] dbg_state;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic glitch_low  = 1'b0;

  // Open-drain wired-AND lines with pull-ups
  assign pc = ~(pc_drive_low | dev_clk_low | glitch_low);
  assign pd = ~(pd_drive_low | dev_dat_low);

  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLEN)
  ) dut (
    .c50         (c50),
    .reset_all   (reset_all),
    .pc          (pc),
    .pd          (pd),
    .pc_drive_low(pc_drive_low),
    .pd_drive_low(pd_drive_low),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .dbg_state   (dbg_state)
  );

  // Clock
  always #10 c50 = ~c50;

  // Pulse counters and inhibit-length monitor
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int inh_run  = 0;
  int inh_last = 0;
  always @(negedge c50) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) both_cnt++;
    if (pc_drive_low) begin
      inh_run++;
    end else if (inh_run != 0) begin
      inh_last = inh_run;
      inh_run  = 0;
    end
  end

  // Reference frame: start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] frame_model(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Driver: present a byte until accepted
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (!tx_ready && n < 5000) begin
      @(negedge c50);
      n++;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge c50);
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL accept: tx_ready=%b busy=%b, required 0 1", tx_ready, busy);
    end
  endtask

  // Device: wait for request, generate nclk clocks, sample on rising edges
  task automatic dev_frame(input bit ack, input bit glitch, input int nclk,
                           output bit ok, output logic [10:0] bits);
    int n;
    ok   = 1'b0;
    bits = '1;
    n    = 0;
    while (!(pc_drive_low == 1'b0 && pd == 1'b0) && n < INH + 200) begin
      @(negedge c50);
      n++;
    end
    if (n >= INH + 200) return;
    bits[0] = pd;
    repeat (HALF) @(negedge c50);
    for (int k = 1; k <= nclk; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge c50);
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k] = pd;
      if (glitch && k >= 3 && k <= 6) begin
        repeat (HALF / 4) @(negedge c50);
        glitch_low = 1'b1;
        repeat (10) @(negedge c50);
        glitch_low = 1'b0;
        repeat (HALF - HALF / 4 - 10) @(negedge c50);
      end else if (k == 10 && ack) begin
        repeat (HALF / 2) @(negedge c50);
        dev_dat_low = 1'b1;
        repeat (HALF - HALF / 2) @(negedge c50);
      end else if (k == 11) begin
        repeat (HALF / 2) @(negedge c50);
        dev_dat_low = 1'b0;
        repeat (HALF - HALF / 2) @(negedge c50);
      end else begin
        repeat (HALF) @(negedge c50);
      end
    end
    ok = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge c50);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic check_frame(input logic [7:0] b, input logic [10:0] bits, input bit ok);
    logic [10:0] f;
    logic [0:0]  e;
    f = frame_model(b);
    for (int i = 0; i < 11; i++) exp_q.push_back(f[i]);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL request_%02h: no request seen, required one", b);
    end
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (bits[i] !== e[0]) begin
        errors++;
        $display("FAIL bit%0d_%02h: got %b, required %b", i, b, bits[i], e[0]);
      end
    end
  endtask

  task automatic test_reset();
    reset_all = 1'b0;
    repeat (3) @(negedge c50);
    checks++;
    if ({pc_drive_low, pd_drive_low, tx_ready, busy, tx_done, tx_err} !== 6'b001000 ||
        dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset: pcl pdl rdy busy done err=%b%b%b%b%b%b state=%0d, required 001000 0",
               pc_drive_low, pd_drive_low, tx_ready, busy, tx_done, tx_err, dbg_state);
    end
    reset_all = 1'b1;
    repeat (3) @(negedge c50);
    checks++;
    if (tx_ready !== 1'b1 || pc_drive_low !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: tx_ready=%b pcl=%b, required 1 0", tx_ready, pc_drive_low);
    end
  endtask

  task automatic test_send(input logic [7:0] b, input bit glitch);
    int d0, e0;
    bit ok;
    logic [10:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(b);
    dev_frame(1'b1, glitch, 11, ok, bits);
    wait_idle();
    @(negedge c50);
    check_frame(b, bits, ok);
    checks++;
    if (inh_last !== INH) begin
      errors++;
      $display("FAIL inhibit_len_%02h: got %0d cycles, required %0d", b, inh_last, INH);
    end
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0 || both_cnt !== 0) begin
      errors++;
      $display("FAIL outcome_%02h: done=%0d err=%0d both=%0d, required 1 0 0",
               b, done_cnt - d0, err_cnt - e0, both_cnt);
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_%02h: got %b, required 1", b, tx_ready);
    end
  endtask

  task automatic test_busy_ignore();
    int d0;
    bit ok;
    logic [10:0] bits;
    logic [7:0] b;
    b  = 8'($urandom_range(0, 255));
    d0 = done_cnt;
    send_byte(b);
    tx_data  = ~b;
    tx_valid = 1'b1;
    repeat (5) @(negedge c50);
    tx_valid = 1'b0;
    dev_frame(1'b1, 1'b0, 11, ok, bits);
    wait_idle();
    check_frame(b, bits, ok);
    repeat (200) @(negedge c50);
    checks++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0 || pc_drive_low !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: done=%0d busy=%b pcl=%b, required 1 0 0",
               done_cnt - d0, busy, pc_drive_low);
    end
  endtask

  task automatic test_timeout();
    int n, d0;
    d0 = done_cnt;
    send_byte(8'($urandom_range(0, 255)));
    n = 0;
    while (pc_drive_low !== 1'b0 && n < INH + 100) begin
      @(negedge c50);
      n++;
    end
    n = 0;
    while (tx_err !== 1'b1 && n < TMO + 200) begin
      @(negedge c50);
      n++;
    end
    checks++;
    if (n !== TMO) begin
      errors++;
      $display("FAIL timeout_len: got %0d cycles, required %0d", n, TMO);
    end
    checks++;
    if (pc_drive_low !== 1'b0 || pd_drive_low !== 1'b0 || dbg_state !== ST_IDLE ||
        done_cnt !== d0) begin
      errors++;
      $display("FAIL timeout_state: pcl=%b pdl=%b state=%0d done=%0d, required 0 0 0 0",
               pc_drive_low, pd_drive_low, dbg_state, done_cnt - d0);
    end
    @(negedge c50);
  endtask

  task automatic test_no_ack();
    int d0, e0;
    bit ok;
    logic [10:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'($urandom_range(0, 255)));
    dev_frame(1'b0, 1'b0, 11, ok, bits);
    wait_idle();
    @(negedge c50);
    checks++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0 || both_cnt !== 0) begin
      errors++;
      $display("FAIL no_ack: err=%0d done=%0d, required 1 0", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [10:0] bits;
    send_byte(8'hFF);
    dev_frame(1'b0, 1'b0, 5, ok, bits);
    @(posedge c50);
    #3 reset_all = 1'b0;
    #1;
    checks++;
    if (pc_drive_low !== 1'b0 || pd_drive_low !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pcl=%b pdl=%b rdy=%b busy=%b, required 0 0 1 0",
               pc_drive_low, pd_drive_low, tx_ready, busy);
    end
    repeat (4) @(negedge c50);
    reset_all = 1'b1;
    repeat (FLEN + 4) @(negedge c50);
    test_send(8'hFF, 1'b0);
  endtask

  initial begin
    test_reset();
    test_send(8'hED, 1'b0);
    test_send(8'hF4, 1'b0);
    test_send(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) test_send(8'($urandom_range(0, 255)), 1'b0);
    test_busy_ignore();
    test_timeout();
    test_no_ack();
    test_send(8'hFF, 1'b1);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable or 0xFF reset.
- Drives the shared clock and data lines open-drain. Assert a drive-low output to pull the line low; release it to let the line float high.
- Sits beside the PS/2 receiver on the same pc/pd pins.
- While busy=1, the top level must gate the receiver.

Parameters:
- INHIBIT_CYCLES, 5000: c50 cycles the clock is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum c50 cycles between filtered device-clock falling edges, and from clock release to the first edge (15 ms).
- FILTER_LEN, 16: length of the glitch-filter shift register on pc.

Ports:
- c50  in  1  system clock, 50 MHz. All logic is on posedge.
- reset_all  in  1  asynchronous, active-low reset.
- pc  in  1  PS/2 clock pin, sensed level.
- pd  in  1  PS/2 data pin, sensed level.
- pc_drive_low  out  1  1 = pull the clock pin low; 0 = release it.
- pd_drive_low  out  1  1 = pull the data pin low; 0 = release it.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  1 when idle and able to accept a byte.
- busy  out  1  1 from accept until return to IDLE.
- tx_done  out  1  one-cycle pulse: frame sent and ACK received.
- tx_err  out  1  one-cycle pulse: timeout or missing ACK.

Behaviour:
- Reset values while reset_all=0, applied immediately (async):
  - state=IDLE; pc_drive_low=0 and pd_drive_low=0 (both lines released at once, even mid-frame).
  - tx_ready=1; busy=0; tx_done=0; tx_err=0.
  - Filter register all ones; filtered clock (pcf)=1; bit counter=0; timer=0.
- Glitch filter on pc:
  - Shift pc into a FILTER_LEN register every cycle.
  - pcf goes to 1 when the register is all ones, to 0 when it is all zeros, and holds otherwise.
  - A falling edge (fall) is pcf 1->0 versus the previous cycle's pcf; fall is registered and lasts one cycle.
  - pd is sampled through 2 synchroniser flops.
- Accept: when tx_valid && tx_ready, latch tx_data and parity = ~^tx_data (odd parity). Go to INHIBIT; tx_ready drops the next cycle.
- A tx_valid that arrives while busy is ignored, not queued.
- INHIBIT state:
  - pc_drive_low=1 for exactly INHIBIT_CYCLES cycles.
  - In the last cycle, set pd_drive_low=1 (start bit), then go to REQ.
- REQ state:
  - pc_drive_low=0, pd_drive_low stays 1, timer cleared.
  - On the first fall: drive bit0 (pd_drive_low = ~data[0]), set bit counter to 1, go to DATA.
- DATA state, on each fall, with the bit counter k incremented after each fall:
  - k=1..7: drive data[k].
  - k=8: drive parity.
  - k=9: release data (stop bit = 1), go to ACK.
  - Data only changes in the cycle after fall, i.e. while the device clock is low.
- ACK state:
  - On fall, sample the synchronised pd.
  - pd=0: go to WAIT_IDLE.
  - pd=1: pulse tx_err, go to IDLE.
- WAIT_IDLE state:
  - Wait for pcf=1 and synchronised pd=1, then pulse tx_done and go to IDLE.
- Timeout:
  - The timer counts in REQ, DATA, ACK and WAIT_IDLE, and clears on every fall.
  - When the timer reaches TIMEOUT_CYCLES: release both lines, pulse tx_err, go to IDLE.
- Exclusivity: tx_done and tx_err are never asserted together; exactly one of them fires per accepted byte.
- Re-accept: a new byte can be accepted in the cycle after the return to IDLE.
- Widths: the timer has ceil(log2(TIMEOUT_CYCLES+1)) bits (20 bits at the default) and saturates, never wrapping. The bit counter is 4 bits.
- Line busy: the block does not wait for the device to finish an in-flight device-to-host frame. Inhibit aborts that frame, which is legal under the PS/2 protocol.

Test Plan:
- Send 0xED; the bench device model clocks at 80 us and ACKs:
  - pc_drive_low high for exactly 5000 cycles.
  - The bits sampled on device rising edges are 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once, tx_err stays 0, and tx_ready returns to 1.
- Send 0xF4 and 0x00: parity bit sampled 0 for 0xF4 and 1 for 0x00; both frames complete with tx_done.
- Device model never clocks after the request: exactly 750000 cycles after clock release, tx_err pulses, both drive outputs are 0, state is IDLE.
- Device model leaves pd high on clock 11: tx_err pulses and tx_done does not.
- Inject 10-cycle low glitches on pc during DATA: no extra bit shift, and the frame for 0xFF still decodes as 0xFF with parity 1.
- Assert reset_all low during DATA bit 4: both drive outputs go to 0 asynchronously and tx_ready=1. After reset is released, a new 0xFF transmits correctly.
